// File: rtl/robo_seguidor_param.sv
// robo_seguidor_param
// Wall-following robot controller. It reads the sensor snapshot reported by
// the map and issues one move command at a time over a valid/ready handshake.
//
// Ports:
//   clock, reset      system clock, asynchronous active-high reset
//   start             pulse, leaves STANDBY (also clears stuck/done)
//   follow_right      wall side (0 left, 1 right), latched in INICIANDO
//   sense_valid       head/side/under/barrier are fresh this cycle
//   head, side        wall in front / wall on the follow side
//   under, barrier    trash in current cell / non-removable obstacle ahead
//   cmd_valid         command pending, held until cmd_ready
//   cmd_ready         map accepts the command
//   avancar, girar,   one-hot command bits (forward, rotate, remove trash)
//   remover
//   girar_dir         0 = rotate away from follow side, 1 = toward it
//   state             current FSM state
//   trash_count       accepted removals, saturating
//   stuck, done       watchdog tripped / step limit reached
//
// Optional feature: define ROBO_STEP_LIMIT_EN to enable the step counter that
// parks the robot with done=1 after MAX_STEPS accepted advances.

module robo_seguidor_param #(
  parameter int WIDTH         = 3,
  parameter int REMOVE_CYCLES = 4,
  parameter int MAX_TURNS     = 4,
  parameter int CNT_W         = 8,
  parameter int MAX_STEPS     = 200
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             follow_right,
  input  logic             sense_valid,
  input  logic             head,
  input  logic             side,
  input  logic             under,
  input  logic             barrier,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic             avancar,
  output logic             girar,
  output logic             girar_dir,
  output logic             remover,
  output logic [WIDTH-1:0] state,
  output logic [CNT_W-1:0] trash_count,
  output logic             stuck,
  output logic             done
);

  typedef enum logic [WIDTH-1:0] {
    PROCURANDO_MURO   = WIDTH'(0),
    ROTACIONANDO      = WIDTH'(1),
    ACOMPANHANDO_MURO = WIDTH'(2),
    INICIANDO         = WIDTH'(3),
    REMOVENDO         = WIDTH'(4),
    STANDBY           = WIDTH'(5)
  } state_t;

  localparam int RC_W = $clog2(REMOVE_CYCLES + 1);
  localparam int TC_W = $clog2(MAX_TURNS + 1);

  state_t            state_q, state_n;
  state_t            return_q, return_n;
  logic [RC_W-1:0]   rem_cnt_q, rem_cnt_n;
  logic [TC_W-1:0]   turn_cnt_q, turn_cnt_n;
  logic              pending_q, pending_n;
  logic              follow_q, follow_n;
  logic              cmd_valid_n, avancar_n, girar_n, girar_dir_n, remover_n;
  logic [CNT_W-1:0]  trash_n;
  logic              stuck_n, done_n;
  logic              accept, decide, blocked;

`ifdef ROBO_STEP_LIMIT_EN
  logic [CNT_W-1:0]  step_cnt_q, step_cnt_n;
`else
  logic [31:0]       unused_max_steps;
  assign unused_max_steps = 32'(MAX_STEPS);
`endif

  // The map already reports 'side' relative to the followed wall, so the
  // latched side does not steer any logic here; it is kept for observation.
  logic unused_follow;
  assign unused_follow = follow_q;

  assign accept  = cmd_valid & cmd_ready;
  assign decide  = sense_valid & ~cmd_valid & ~pending_q;
  assign blocked = head | barrier;
  assign state   = state_q;

  // Next-state and registered-output logic. A handshake completion clears
  // the command first; the state case may then issue a new command, and the
  // watchdog/step-limit checks run last so they override any state change.
  always_comb begin
    state_n     = state_q;
    return_n    = return_q;
    rem_cnt_n   = rem_cnt_q;
    turn_cnt_n  = turn_cnt_q;
    pending_n   = pending_q;
    follow_n    = follow_q;
    cmd_valid_n = cmd_valid;
    avancar_n   = avancar;
    girar_n     = girar;
    girar_dir_n = girar_dir;
    remover_n   = remover;
    trash_n     = trash_count;
    stuck_n     = stuck;
    done_n      = done;
`ifdef ROBO_STEP_LIMIT_EN
    step_cnt_n  = step_cnt_q;
`endif

    if (accept) begin
      cmd_valid_n = 1'b0;
      avancar_n   = 1'b0;
      girar_n     = 1'b0;
      girar_dir_n = 1'b0;
      remover_n   = 1'b0;
    end

    case (state_q)
      STANDBY: begin
        if (start) begin
          state_n = INICIANDO;
          stuck_n = 1'b0;
          done_n  = 1'b0;
        end
      end
      INICIANDO: begin
        follow_n   = follow_right;
        turn_cnt_n = '0;
        pending_n  = 1'b0;
`ifdef ROBO_STEP_LIMIT_EN
        step_cnt_n = '0;
`endif
        state_n    = PROCURANDO_MURO;
      end
      PROCURANDO_MURO: begin
        if (decide) begin
          if (under) begin
            cmd_valid_n = 1'b1;
            remover_n   = 1'b1;
            return_n    = PROCURANDO_MURO;
            state_n     = REMOVENDO;
          end else if (side) begin
            state_n = ACOMPANHANDO_MURO;
          end else if (blocked) begin
            cmd_valid_n = 1'b1;
            girar_n     = 1'b1;
            girar_dir_n = 1'b0;
            state_n     = ROTACIONANDO;
          end else begin
            cmd_valid_n = 1'b1;
            avancar_n   = 1'b1;
          end
        end
      end
      ROTACIONANDO: begin
        if (accept) state_n = ACOMPANHANDO_MURO;
      end
      ACOMPANHANDO_MURO: begin
        // Turning toward a lost wall must be followed by a step forward,
        // otherwise the robot would keep seeing no wall and spin.
        if (pending_q && !cmd_valid) begin
          cmd_valid_n = 1'b1;
          avancar_n   = 1'b1;
          pending_n   = 1'b0;
        end else if (decide) begin
          if (under) begin
            cmd_valid_n = 1'b1;
            remover_n   = 1'b1;
            return_n    = ACOMPANHANDO_MURO;
            state_n     = REMOVENDO;
          end else if (!side) begin
            cmd_valid_n = 1'b1;
            girar_n     = 1'b1;
            girar_dir_n = 1'b1;
            pending_n   = 1'b1;
          end else if (blocked) begin
            cmd_valid_n = 1'b1;
            girar_n     = 1'b1;
            girar_dir_n = 1'b0;
          end else begin
            cmd_valid_n = 1'b1;
            avancar_n   = 1'b1;
          end
        end
      end
      REMOVENDO: begin
        if (accept && remover) begin
          rem_cnt_n = RC_W'(REMOVE_CYCLES);
          if (trash_count != '1) trash_n = trash_count + CNT_W'(1);
        end else if (!cmd_valid && rem_cnt_q != '0) begin
          rem_cnt_n = rem_cnt_q - RC_W'(1);
          if (rem_cnt_q == RC_W'(1)) state_n = return_q;
        end
      end
      default: state_n = STANDBY;
    endcase

    if (accept && girar) begin
      turn_cnt_n = turn_cnt_q + TC_W'(1);
      if (turn_cnt_q == TC_W'(MAX_TURNS - 1)) begin
        state_n   = STANDBY;
        stuck_n   = 1'b1;
        pending_n = 1'b0;
      end
    end else if (accept && avancar) begin
      turn_cnt_n = '0;
`ifdef ROBO_STEP_LIMIT_EN
      step_cnt_n = step_cnt_q + CNT_W'(1);
      if (step_cnt_q == CNT_W'(MAX_STEPS - 1)) begin
        state_n   = STANDBY;
        done_n    = 1'b1;
        pending_n = 1'b0;
      end
`endif
    end
  end

  // State and output registers; reset abandons any command in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= STANDBY;
      return_q    <= PROCURANDO_MURO;
      rem_cnt_q   <= '0;
      turn_cnt_q  <= '0;
      pending_q   <= 1'b0;
      follow_q    <= 1'b0;
      cmd_valid   <= 1'b0;
      avancar     <= 1'b0;
      girar       <= 1'b0;
      girar_dir   <= 1'b0;
      remover     <= 1'b0;
      trash_count <= '0;
      stuck       <= 1'b0;
      done        <= 1'b0;
`ifdef ROBO_STEP_LIMIT_EN
      step_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_n;
      return_q    <= return_n;
      rem_cnt_q   <= rem_cnt_n;
      turn_cnt_q  <= turn_cnt_n;
      pending_q   <= pending_n;
      follow_q    <= follow_n;
      cmd_valid   <= cmd_valid_n;
      avancar     <= avancar_n;
      girar       <= girar_n;
      girar_dir   <= girar_dir_n;
      remover     <= remover_n;
      trash_count <= trash_n;
      stuck       <= stuck_n;
      done        <= done_n;
`ifdef ROBO_STEP_LIMIT_EN
      step_cnt_q  <= step_cnt_n;
`endif
    end
  end

endmodule
